// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
//
// Multi-cycle 32-bit integer divider for the DIV/DIVU instructions. Operands
// come straight from the register-file read ports (rs = dividend, rt =
// divisor). A restoring shift-subtract loop runs for 32 iterations on operand
// magnitudes, and the latched signs are applied in a final cycle. Quotient
// goes to LO and remainder goes to HI.
//
// Handshake: `start` is a request and `busy`=0 is the matching ready. A
// division is accepted on the rising edge where start=1 and busy=0. The
// operands are captured on that edge and do not have to be held afterwards.
// A start seen while busy=1 is dropped, not queued. Completion is a one-cycle
// `done` pulse. `quotient`/`remainder` are valid from that pulse and hold until
// the next completion.
//
// Ports:
//   clk          in   1   clock; all state changes on the rising edge
//   rst          in   1   synchronous, active-high reset (aborts any run)
//   start        in   1   division request, honoured only while busy=0
//   is_signed    in   1   1 = DIV (two's complement), 0 = DIVU
//   dividend     in  32   rs value
//   divisor      in  32   rt value
//   busy         out  1   division in progress (RUN or FIN)
//   done         out  1   one-cycle pulse, results just updated
//   quotient     out 32   LO result
//   remainder    out 32   HI result
//   dbg_state_o  out  2   current FSM state (IDLE=0, RUN=1, FIN=2)
// -----------------------------------------------------------------------------
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;      // iteration index 0..31
  logic [31:0] rem_q, rem_d;      // partial remainder
  logic [31:0] dvd_q, dvd_d;      // dividend bits shift out, quotient bits shift in
  logic [31:0] dvs_q, dvs_d;      // divisor magnitude
  logic        q_neg_q, q_neg_d;  // quotient must be negated at the end
  logic        r_neg_q, r_neg_d;  // remainder must be negated at the end
  logic [31:0] quot_q, quot_d;
  logic [31:0] rmd_q, rmd_d;
  logic        done_q, done_d;

  // Operand signs and magnitudes. For DIVU the operands are taken as-is.
  // |0x80000000| stays 0x80000000, which is correct when read as unsigned.
  logic        dvd_neg, dvs_neg;
  logic [31:0] dvd_abs, dvs_abs;

  assign dvd_neg = is_signed & dividend[31];
  assign dvs_neg = is_signed & divisor[31];
  assign dvd_abs = dvd_neg ? (~dividend + 32'd1) : dividend;
  assign dvs_abs = dvs_neg ? (~divisor + 32'd1) : divisor;

  // One restoring step. The shifted partial remainder is 33 bits wide. When
  // the trial subtraction succeeds, the difference is smaller than the divisor,
  // so a 32-bit subtraction already gives the exact kept value.
  logic [32:0] shifted;
  logic        keep;
  logic [31:0] diff;

  assign shifted = {rem_q, dvd_q[31]};
  assign keep    = (shifted >= {1'b0, dvs_q});
  assign diff    = shifted[31:0] - dvs_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    quot_d  = quot_q;
    rmd_d   = rmd_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          dvd_d   = dvd_abs;
          dvs_d   = dvs_abs;
          // With a zero divisor, dvs_neg is 0, so the quotient sign follows
          // the dividend. That produces q=1 for a negative dividend.
          q_neg_d = dvd_neg ^ dvs_neg;
          r_neg_d = dvd_neg;
          rem_d   = 32'd0;
          cnt_d   = 5'd0;
        end
      end

      RUN: begin
        dvd_d = {dvd_q[30:0], keep};
        rem_d = keep ? diff : shifted[31:0];
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = FIN;
        end
      end

      FIN: begin
        quot_d  = q_neg_q ? (~dvd_q + 32'd1) : dvd_q;
        rmd_d   = r_neg_q ? (~rem_q + 32'd1) : rem_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      rem_q   <= 32'd0;
      dvd_q   <= 32'd0;
      dvs_q   <= 32'd0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      quot_q  <= 32'd0;
      rmd_q   <= 32'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      quot_q  <= quot_d;
      rmd_q   <= rmd_d;
      done_q  <= done_d;
    end
  end

  // done is registered out of FIN, so it is high only while the FSM is back
  // in IDLE. That keeps busy and done mutually exclusive.
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rmd_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_div_unit.sv
// -----------------------------------------------------------------------------
// tb_div_unit: directed tests for div_unit with hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic [1:0]  dbg_state;

  int chk_total;
  int chk_pass;

  div_unit dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .dbg_state_o (dbg_state)
  );

  // Clock and watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver: issue one division, then scramble the operand inputs to show they
  // need not be held. Samples on negedges until done, bounded at 40 cycles.
  // Returns the results and the number of sampled cycles with busy=1.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output logic [31:0] q, output logic [31:0] r,
                         output int busy_n, output bit got);
    dividend  = a;
    divisor   = b;
    is_signed = s;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    dividend  = 32'hDEAD_BEEF;
    divisor   = 32'h0000_0003;
    is_signed = ~s;
    busy_n = 0; got = 1'b0; q = '0; r = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1; q = quotient; r = remainder;
        break;
      end
      if (busy) busy_n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else chk_pass++;
    chk_total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else chk_pass++;
    chk_total++; if (quotient !== 32'd0) $display("FAIL reset_q: got %h want 00000000", quotient); else chk_pass++;
    chk_total++; if (remainder !== 32'd0) $display("FAIL reset_r: got %h want 00000000", remainder); else chk_pass++;
    chk_total++; if (dbg_state !== 2'd0) $display("FAIL reset_state: got %0d want 0", dbg_state); else chk_pass++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_unsigned();
    logic [31:0] q, r;
    int bn;
    bit got;
    run_div(32'd100, 32'd7, 1'b0, q, r, bn, got);
    chk_total++; if (got !== 1'b1) $display("FAIL divu_100_7_done: got %b want 1", got); else chk_pass++;
    chk_total++; if (bn != 33) $display("FAIL divu_busy_cycles: got %0d want 33", bn); else chk_pass++;
    chk_total++; if (q !== 32'd14) $display("FAIL divu_100_7_q: got %h want %h", q, 32'd14); else chk_pass++;
    chk_total++; if (r !== 32'd2) $display("FAIL divu_100_7_r: got %h want %h", r, 32'd2); else chk_pass++;
    chk_total++; if (busy !== 1'b0) $display("FAIL busy_in_done_cycle: got %b want 0", busy); else chk_pass++;
    @(negedge clk);
    chk_total++; if (done !== 1'b0) $display("FAIL done_one_cycle: got %b want 0", done); else chk_pass++;
    chk_total++; if (quotient !== 32'd14) $display("FAIL divu_q_hold: got %h want %h", quotient, 32'd14); else chk_pass++;
    // The same bit pattern as -7, divided as unsigned.
    run_div(32'hFFFF_FFF9, 32'd2, 1'b0, q, r, bn, got);
    chk_total++; if (got !== 1'b1) $display("FAIL divu_big_done: got %b want 1", got); else chk_pass++;
    chk_total++; if (q !== 32'h7FFF_FFFC) $display("FAIL divu_big_q: got %h want 7ffffffc", q); else chk_pass++;
    chk_total++; if (r !== 32'd1) $display("FAIL divu_big_r: got %h want 00000001", r); else chk_pass++;
    @(negedge clk);
  endtask

  task automatic test_signed();
    logic [31:0] va [4] = '{32'hFFFF_FFF9, 32'd7,        32'hFFFF_FFF9, 32'd100};
    logic [31:0] vb [4] = '{32'd2,        32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFF9};
    logic [31:0] eq [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'd3,        32'hFFFF_FFF2};
    logic [31:0] er [4] = '{32'hFFFF_FFFF, 32'd1,        32'hFFFF_FFFF, 32'd2};
    logic [31:0] q, r;
    int bn;
    bit got;
    for (int k = 0; k < 4; k++) begin
      run_div(va[k], vb[k], 1'b1, q, r, bn, got);
      chk_total++; if (got !== 1'b1) $display("FAIL div_signed_done[%0d]: got %b want 1", k, got); else chk_pass++;
      chk_total++; if (q !== eq[k]) $display("FAIL div_signed_q[%0d]: got %h want %h", k, q, eq[k]); else chk_pass++;
      chk_total++; if (r !== er[k]) $display("FAIL div_signed_r[%0d]: got %h want %h", k, r, er[k]); else chk_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_div_zero();
    logic [31:0] va [3] = '{32'h1234_5678, 32'hFFFF_FF00, 32'd5};
    logic        vs [3] = '{1'b0,         1'b1,         1'b1};
    logic [31:0] eq [3] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF};
    logic [31:0] er [3] = '{32'h1234_5678, 32'hFFFF_FF00, 32'd5};
    logic [31:0] q, r;
    int bn;
    bit got;
    for (int k = 0; k < 3; k++) begin
      run_div(va[k], 32'd0, vs[k], q, r, bn, got);
      chk_total++; if (got !== 1'b1) $display("FAIL div0_done[%0d]: got %b want 1", k, got); else chk_pass++;
      chk_total++; if (q !== eq[k]) $display("FAIL div0_q[%0d]: got %h want %h", k, q, eq[k]); else chk_pass++;
      chk_total++; if (r !== er[k]) $display("FAIL div0_r[%0d]: got %h want %h", k, r, er[k]); else chk_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_extremes();
    logic [31:0] va [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [31:0] vb [3] = '{32'hFFFF_FFFF, 32'd1,        32'hFFFF_FFFF};
    logic        vs [3] = '{1'b1,         1'b0,         1'b0};
    logic [31:0] eq [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'd0};
    logic [31:0] er [3] = '{32'd0,        32'd0,        32'h8000_0000};
    logic [31:0] q, r;
    int bn;
    bit got;
    for (int k = 0; k < 3; k++) begin
      run_div(va[k], vb[k], vs[k], q, r, bn, got);
      chk_total++; if (got !== 1'b1) $display("FAIL extreme_done[%0d]: got %b want 1", k, got); else chk_pass++;
      chk_total++; if (q !== eq[k]) $display("FAIL extreme_q[%0d]: got %h want %h", k, q, eq[k]); else chk_pass++;
      chk_total++; if (r !== er[k]) $display("FAIL extreme_r[%0d]: got %h want %h", k, r, er[k]); else chk_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_start_ignored();
    int at;
    int extra;
    logic [31:0] q, r;
    dividend = 32'd1000; divisor = 32'd7; is_signed = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    at = 0; q = '0; r = '0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done) begin
        at = i; q = quotient; r = remainder;
        break;
      end
      if (i == 5 || i == 20) begin
        start = 1'b1; dividend = 32'd77; divisor = 32'd5; is_signed = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk_total++; if (at != 34) $display("FAIL ignore_done_cycle: got %0d want 34", at); else chk_pass++;
    chk_total++; if (q !== 32'd142) $display("FAIL ignore_q: got %h want %h", q, 32'd142); else chk_pass++;
    chk_total++; if (r !== 32'd6) $display("FAIL ignore_r: got %h want %h", r, 32'd6); else chk_pass++;
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    chk_total++; if (extra != 0) $display("FAIL ignore_no_second_run: got %0d active cycles want 0", extra); else chk_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] q, r;
    int bn;
    bit got;
    bit held;
    int at;
    run_div(32'd100, 32'd7, 1'b0, q, r, bn, got);
    chk_total++; if (q !== 32'd14 || r !== 32'd2) $display("FAIL b2b_first: got %h/%h want 0000000e/00000002", q, r); else chk_pass++;
    // Still in the done cycle: request the next division right away.
    dividend = 32'd50; divisor = 32'd6; is_signed = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; dividend = 32'h0BAD_F00D;
    held = 1'b1; at = 0; q = '0; r = '0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done) begin
        at = i; q = quotient; r = remainder;
        break;
      end
      if (quotient !== 32'd14 || remainder !== 32'd2) held = 1'b0;
    end
    chk_total++; if (held !== 1'b1) $display("FAIL b2b_results_held: got %b want 1", held); else chk_pass++;
    chk_total++; if (at != 34) $display("FAIL b2b_done_cycle: got %0d want 34", at); else chk_pass++;
    chk_total++; if (q !== 32'd8) $display("FAIL b2b_q: got %h want %h", q, 32'd8); else chk_pass++;
    chk_total++; if (r !== 32'd2) $display("FAIL b2b_r: got %h want %h", r, 32'd2); else chk_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    int seen;
    logic [31:0] q, r;
    int bn;
    bit got;
    dividend = 32'd200; divisor = 32'd9; is_signed = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i <= 10; i++) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_total++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy); else chk_pass++;
    chk_total++; if (quotient !== 32'd0) $display("FAIL midrst_q: got %h want 00000000", quotient); else chk_pass++;
    chk_total++; if (remainder !== 32'd0) $display("FAIL midrst_r: got %h want 00000000", remainder); else chk_pass++;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk_total++; if (seen != 0) $display("FAIL midrst_no_done: got %0d pulses want 0", seen); else chk_pass++;
    run_div(32'd9, 32'd3, 1'b0, q, r, bn, got);
    chk_total++; if (got !== 1'b1) $display("FAIL after_rst_done: got %b want 1", got); else chk_pass++;
    chk_total++; if (bn != 33) $display("FAIL after_rst_busy_cycles: got %0d want 33", bn); else chk_pass++;
    chk_total++; if (q !== 32'd3) $display("FAIL after_rst_q: got %h want %h", q, 32'd3); else chk_pass++;
    chk_total++; if (r !== 32'd0) $display("FAIL after_rst_r: got %h want %h", r, 32'd0); else chk_pass++;
    @(negedge clk);
  endtask

  initial begin
    chk_total = 0;
    chk_pass  = 0;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_extremes();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", chk_pass, chk_total);
    $finish;
  end

endmodule
